// File: rtl/cpu_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_ctrl
//   Sequencing controller for a 4-entry register file. It accepts one 10-bit
//   instruction at a time over a valid/ready handshake, reads operands through
//   the RF's two read ports, runs a small ALU operation, and then either
//   writes the result back or emits a register value on an output handshake.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   instr_valid_i/ready_o    instruction handshake; ready only while IDLE
//   instr_i                  {op[9:6], rd[5:4], ra[3:2], rb[1:0]}
//   data_i                   LOAD operand, captured at accept
//   wr_en_o/wr_addr_o/data_RF_o        RF write port (registered)
//   rd_A_en_o/rd_A_addr_o/data_A_i     RF read port A (data one cycle later)
//   rd_B_en_o/rd_B_addr_o/data_B_i     RF read port B (data one cycle later)
//   out_data_o/out_valid_o/out_ready_i STORE output handshake
//   flag_z_o, flag_c_o       zero / carry-borrow of the last ALU op
//   illegal_o                one-cycle pulse after accepting an undefined op
//   busy_o                   controller not in IDLE
// ---------------------------------------------------------------------------
module cpu_ctrl #(
  parameter int REG_WID = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  input  logic [9:0]         instr_i,
  input  logic [REG_WID-1:0] data_i,
  output logic [REG_WID-1:0] data_RF_o,
  output logic               wr_en_o,
  output logic [1:0]         wr_addr_o,
  output logic               rd_A_en_o,
  output logic [1:0]         rd_A_addr_o,
  output logic               rd_B_en_o,
  output logic [1:0]         rd_B_addr_o,
  input  logic [REG_WID-1:0] data_A_i,
  input  logic [REG_WID-1:0] data_B_i,
  output logic [REG_WID-1:0] out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               flag_z_o,
  output logic               flag_c_o,
  output logic               illegal_o,
  output logic               busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_EXEC, S_WB, S_OUT
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_MOV   = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_STORE = 4'd8;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
  } instr_t;

  instr_t instr;
  assign instr = instr_t'(instr_i);

  state_t               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [1:0]           rd_q, rd_d;
  logic [REG_WID-1:0]   data_RF_q, data_RF_d;
  logic                 wr_en_q, wr_en_d;
  logic [1:0]           wr_addr_q, wr_addr_d;
  logic                 rd_A_en_q, rd_A_en_d;
  logic [1:0]           rd_A_addr_q, rd_A_addr_d;
  logic                 rd_B_en_q, rd_B_en_d;
  logic [1:0]           rd_B_addr_q, rd_B_addr_d;
  logic [REG_WID-1:0]   out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 flag_z_q, flag_z_d;
  logic                 flag_c_q, flag_c_d;
  logic                 illegal_q, illegal_d;

  logic                 accept;
  logic [REG_WID:0]     sum, diff;
  logic [REG_WID-1:0]   alu_res;

  assign instr_ready_o = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign accept        = instr_valid_i && instr_ready_o;

  // One extra bit on both: sum[MSB] is the carry, diff[MSB] is the borrow
  // (set exactly when data_A_i < data_B_i as unsigned values).
  assign sum  = {1'b0, data_A_i} + {1'b0, data_B_i};
  assign diff = {1'b0, data_A_i} - {1'b0, data_B_i};

  always_comb begin
    alu_res = data_A_i;
    case (op_q)
      OP_ADD:  alu_res = sum[REG_WID-1:0];
      OP_SUB:  alu_res = diff[REG_WID-1:0];
      OP_AND:  alu_res = data_A_i & data_B_i;
      OP_OR:   alu_res = data_A_i | data_B_i;
      OP_XOR:  alu_res = data_A_i ^ data_B_i;
      default: alu_res = data_A_i;   // MOV (and STORE, which ignores it)
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    data_RF_d   = data_RF_q;
    wr_addr_d   = wr_addr_q;
    rd_A_addr_d = rd_A_addr_q;
    rd_B_addr_d = rd_B_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    flag_z_d    = flag_z_q;
    flag_c_d    = flag_c_q;
    // Strobes are single-cycle unless a state explicitly raises them.
    wr_en_d     = 1'b0;
    rd_A_en_d   = 1'b0;
    rd_B_en_d   = 1'b0;
    illegal_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = instr.op;
          rd_d = instr.rd;
          case (instr.op)
            OP_NOP: ;
            OP_LOAD: begin
              // LOAD skips the read/exec stages: raise the write strobe
              // now so it is visible in the WB cycle right after accept.
              state_d   = S_WB;
              wr_en_d   = 1'b1;
              wr_addr_d = instr.rd;
              data_RF_d = data_i;
            end
            OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_STORE: begin
              state_d     = S_READ;
              rd_A_en_d   = 1'b1;
              rd_A_addr_d = instr.ra;
              rd_B_en_d   = 1'b1;
              rd_B_addr_d = instr.rb;
            end
            default: illegal_d = 1'b1;
          endcase
        end
      end

      S_READ: state_d = S_EXEC;

      S_EXEC: begin
        if (op_q == OP_STORE) begin
          state_d     = S_OUT;
          out_data_d  = data_A_i;
          out_valid_d = 1'b1;
        end else begin
          state_d   = S_WB;
          wr_en_d   = 1'b1;
          wr_addr_d = rd_q;
          data_RF_d = alu_res;
          flag_z_d  = (alu_res == '0);
          if (op_q == OP_ADD) flag_c_d = sum[REG_WID];
          if (op_q == OP_SUB) flag_c_d = diff[REG_WID];
        end
      end

      S_WB: state_d = S_IDLE;

      S_OUT: begin
        if (out_ready_i) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      data_RF_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      rd_A_en_q   <= 1'b0;
      rd_A_addr_q <= '0;
      rd_B_en_q   <= 1'b0;
      rd_B_addr_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      data_RF_q   <= data_RF_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      rd_A_en_q   <= rd_A_en_d;
      rd_A_addr_q <= rd_A_addr_d;
      rd_B_en_q   <= rd_B_en_d;
      rd_B_addr_q <= rd_B_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      flag_z_q    <= flag_z_d;
      flag_c_q    <= flag_c_d;
      illegal_q   <= illegal_d;
    end
  end

  assign data_RF_o   = data_RF_q;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign rd_A_en_o   = rd_A_en_q;
  assign rd_A_addr_o = rd_A_addr_q;
  assign rd_B_en_o   = rd_B_en_q;
  assign rd_B_addr_o = rd_B_addr_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign flag_z_o    = flag_z_q;
  assign flag_c_o    = flag_c_q;
  assign illegal_o   = illegal_q;

endmodule
